// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry processes one
// operand bit pair per clock, LSB first, and presents the parallel result with a done strobe.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic             carry_nxt;
    logic             bit_val;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             last;

    assign bit_val   = sa[0] ^ sb[0] ^ carry;
    assign carry_nxt = (sa[0] & sb[0]) | (sb[0] & carry) | (carry & sa[0]);
    // New sum bit enters at the MSB so that after WIDTH shifts the LSB has reached bit 0.
    assign acc_nxt   = (acc >> 1) | (WIDTH'(bit_val) << (WIDTH - 1));
    assign last      = (cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= carry_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt + CW'(1);
            // Result registers only move on the final bit, so they hold between results.
            if (last) begin
                sum  <= acc_nxt;
                cout <= carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed corner cases plus a random
// sweep compared against plain-arithmetic a+b+cin and the WIDTH+1 cycle latency rule.
module tb_bit_serial_adder;

    parameter int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] last_sum;
    logic             last_cout;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
        return {1'b0, x} + {1'b0, y} + (WIDTH + 1)'(c);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts edges until done; every cycle before it must show busy with the old result held.
    task automatic waitDone(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            checkOutput("hold", {63'(busy), cout, sum} >> 0, {1'b1, last_cout, last_sum});
        end
        if (!done) n = limit + 1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vc, input string tag);
        logic [WIDTH:0] exp;
        int             n;
        exp   = model(va, vb, vc);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        waitDone(WIDTH + 4, n);
        checkOutput({tag, "_latency"}, 64'(n), 64'(WIDTH));
        checkOutput({tag, "_result"}, 64'({cout, sum}), 64'(exp));
        checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        last_sum  = exp[WIDTH-1:0];
        last_cout = exp[WIDTH];
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [WIDTH:0] exp1;
        logic [WIDTH:0] exp2;
        int             n;
        int             extra_done;
        rst_n     = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        last_sum  = '0;
        last_cout = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_async", 64'({busy, done, cout, sum}), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 64'({busy, done, cout, sum}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_release", 64'({busy, done, cout, sum}), 64'd0);

        applyStimulus(WIDTH'(8'h5A), WIDTH'(8'h3C), 1'b0, "basic");
        applyStimulus('1, WIDTH'(1), 1'b0, "wrap_ff_01");
        applyStimulus('1, '1, 1'b1, "wrap_ff_ff_c");
        applyStimulus('0, '0, 1'b1, "zero_cin");

        // start held high: the DONE-cycle start is accepted with the operands present then.
        exp1  = model(WIDTH'(8'h10), WIDTH'(8'h20), 1'b0);
        exp2  = model(WIDTH'(8'h01), WIDTH'(8'h02), 1'b0);
        a     = WIDTH'(8'h10);
        b     = WIDTH'(8'h20);
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = WIDTH'(8'h01);
        b = WIDTH'(8'h02);
        waitDone(WIDTH + 4, n);
        checkOutput("held_first_latency", 64'(n), 64'(WIDTH));
        checkOutput("held_first_result", 64'({cout, sum}), 64'(exp1));
        last_sum  = exp1[WIDTH-1:0];
        last_cout = exp1[WIDTH];
        waitDone(WIDTH + 5, n);
        checkOutput("held_second_latency", 64'(n), 64'(WIDTH + 1));
        checkOutput("held_second_result", 64'({cout, sum}), 64'(exp2));
        last_sum  = exp2[WIDTH-1:0];
        last_cout = exp2[WIDTH];
        start = 1'b0;
        extra_done = 0;
        repeat (WIDTH + 3) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        checkOutput("held_extra_done", 64'(extra_done), 64'd0);

        // A start pulse while busy must be ignored.
        exp1  = model(WIDTH'(8'h21), WIDTH'(8'h43), 1'b1);
        a     = WIDTH'(8'h21);
        b     = WIDTH'(8'h43);
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        a     = WIDTH'(8'hE7);
        b     = WIDTH'(8'h9B);
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (done) begin
            n = 1;
        end else begin
            waitDone(WIDTH + 4, n);
            n = n + 1;
        end
        checkOutput("busy_start_latency", 64'(n), 64'(WIDTH));
        checkOutput("busy_start_result", 64'({cout, sum}), 64'(exp1));
        last_sum  = exp1[WIDTH-1:0];
        last_cout = exp1[WIDTH];
        extra_done = 0;
        repeat (WIDTH + 3) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        checkOutput("busy_start_extra_done", 64'(extra_done), 64'd0);

        // Reset in the middle of a run discards the result.
        a     = WIDTH'(8'hAA);
        b     = WIDTH'(8'h55);
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat ((WIDTH - 1 < 3) ? WIDTH - 1 : 3) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_async", 64'({busy, done, cout, sum}), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        extra_done = 0;
        repeat (WIDTH + 3) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        checkOutput("midreset_no_done", 64'(extra_done), 64'd0);
        checkOutput("midreset_sum", 64'({cout, sum}), 64'd0);
        last_sum  = '0;
        last_cout = 1'b0;
        applyStimulus(WIDTH'(1), WIDTH'(1), 1'b0, "after_reset");

        for (int i = 0; i < 1000; i++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Bit-serial N-bit adder built around a single 1-bit full-adder cell with a registered carry. One operand bit pair per clock, LSB first.
- Parallel operands and carry-in are loaded on a start pulse. Parallel sum and carry-out are presented with a one-cycle done strobe.
- Sits upstream of result consumers. It is the area-minimal alternative to a ripple chain of full adders.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request: load a, b, cin and begin addition; sampled on rising clk
a  input  WIDTH  operand A, sampled only on an accepted start
b  input  WIDTH  operand B, sampled only on an accepted start
cin  input  1  carry-in, sampled only on an accepted start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle strobe: sum/cout hold a new result
sum  output  WIDTH  registered result a+b+cin mod 2^WIDTH
cout  output  1  registered carry-out of the MSB

Behaviour:
- Reset: one clock and an asynchronous active-low reset (clk, rst_n). rst_n low forces the following immediately, independent of clk:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0
  - internal shift registers, carry flop and bit counter = 0
- State machine: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: load sa<=a, sb<=b, carry<=cin, acc<=0, cnt<=0; go to RUN.
- RUN (busy=1), at each edge:
  - bit = sa[0]^sb[0]^carry.
  - carry <= sa[0]&sb[0] | sb[0]&carry | carry&sa[0].
  - acc shifts right with bit entering at MSB; sa, sb shift right; cnt increments.
  - On the edge that processes bit WIDTH-1 (cnt==WIDTH-1): sum<=final acc value (including this bit), cout<=new carry value; go to DONE.
- DONE (busy=0, done=1 for exactly this one cycle):
  - start=1: accept and load exactly as in IDLE; go to RUN (back-to-back operation).
  - Otherwise: go to IDLE.
- Latency:
  - start sampled at edge k → done high during the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles after start.
  - busy is high from edge k to edge k+WIDTH.
  - Throughput: one addition per WIDTH+1 cycles.
- start while busy=1 is ignored; operands are not resampled and the in-flight computation is unaffected.
- sum/cout change only on the transition into DONE (and on reset). Between results they hold the last value. They do not change during RUN.
- Arithmetic: {cout,sum} == a + b + cin, computed at WIDTH+1 bits; no overflow flag.
- Wrap-around: an all-ones operand plus carry-in produces correct modulo result with cout=1.
- cnt width = max(1, clog2(WIDTH)). WIDTH=1 completes in a single RUN cycle.
- Reset mid-operation: the result is discarded and done is not asserted. The next start after rst_n release behaves as from power-up.
- a, b, cin may change freely after the accepting edge.

Test Plan:
- Reset check: rst_n=0 asserted asynchronously between edges → busy=0, done=0, sum=0x00, cout=0 immediately; held through release.
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse → busy high 8 cycles; done high in cycle 9 after start; sum=0x96, cout=0. Change a to 0x00 mid-run: result unchanged.
- Carry-chain boundary cases:
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
  - a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Protocol:
  - start held high continuously with a=0x10, b=0x20, changing operands to a=0x01, b=0x02 mid-run → first done gives 0x30. Start in the DONE cycle is accepted, so the second done arrives exactly 9 cycles later with 0x03. No extra done pulses.
  - start pulse while busy=1 is ignored: done count and result match the original operands.
- Reset mid-operation: rst_n low at RUN cycle 4 of a=0xAA, b=0x55, then released → no done, sum=0x00. New start with a=0x01, b=0x01 → sum=0x02 after 9 cycles.
- Randomized sweep, 1000 vectors, WIDTH=8 and WIDTH=1 builds: {cout,sum} equals a+b+cin for every result; done is always one cycle wide.
